// File: rtl/uart_arb_pkg.sv
// Shared encodings for the UART transmit arbiter: state codes and the source-tag header byte.
package uart_arb_pkg;

    localparam int STW = 3;

    localparam logic [STW-1:0] IDLE = 3'd0;
    localparam logic [STW-1:0] SEND = 3'd1;
    localparam logic [STW-1:0] WAIT = 3'd2;
    localparam logic [STW-1:0] NEXT = 3'd3;
    localparam logic [STW-1:0] HDR  = 3'd4;

    localparam logic [7:0] SRC_ID_TAG = 8'hA0;

    typedef enum logic [STW-1:0] {
        ST_IDLE = IDLE,
        ST_SEND = SEND,
        ST_WAIT = WAIT,
        ST_NEXT = NEXT,
        ST_HDR  = HDR
    } state_t;

    // Header byte announcing which source owns the following packet.
    function automatic logic [7:0] src_tag(input logic [3:0] id);
        return SRC_ID_TAG | {4'h0, id};
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request scanning upward from the
// index after i_last, wrapping, so the previous owner has lowest priority.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDW-1:0]     i_last,
    output logic               o_any,
    output logic [IDW-1:0]     o_winner
);

    logic [IDW-1:0] w_idx;

    always_comb begin
        o_any    = |i_req;
        o_winner = i_last;
        w_idx    = i_last;
        // Walk from lowest to highest priority; the last hit is the winner.
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_idx = IDW'((int'(i_last) + k) % NUM_REQ);
            if (i_req[w_idx]) begin
                o_winner = w_idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter sharing one UART transmitter among NUM_REQ byte sources.
// Define UART_TX_ARB_SRC_ID_EN to prefix every packet with a source-tag header byte.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2,
    parameter int PKT_MAX = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_last,
    input  logic [NUM_REQ*8-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_din,
    input  logic                 tx_done_tick,
    output logic                 busy,
    output logic [IDW-1:0]       grant_id,
    output logic                 pkt_abort
);

    state_t             r_state;
    logic [IDW-1:0]     r_grant;
    logic [7:0]         r_cnt;
    logic               r_last;
    logic               r_tx_start;
    logic [7:0]         r_tx_din;
    logic [NUM_REQ-1:0] r_req_ready;
    logic               r_busy;
    logic               r_pkt_abort;

    logic               w_any;
    logic [IDW-1:0]     w_winner;
    logic [7:0]         w_win_data;
    logic [7:0]         w_own_data;
    logic [NUM_REQ-1:0] w_win_onehot;
    logic [NUM_REQ-1:0] w_own_onehot;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr_pick (
        .i_req    (req_valid),
        .i_last   (r_grant),
        .o_any    (w_any),
        .o_winner (w_winner)
    );

    assign w_win_data   = req_data[{w_winner, 3'b000} +: 8];
    assign w_own_data   = req_data[{r_grant, 3'b000} +: 8];
    assign w_win_onehot = NUM_REQ'(1) << w_winner;
    assign w_own_onehot = NUM_REQ'(1) << r_grant;

    // Outputs are registered so that tx_start/req_ready/tx_din line up with the SEND cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_grant     <= IDW'(NUM_REQ - 1);
            r_cnt       <= 8'd0;
            r_last      <= 1'b0;
            r_tx_start  <= 1'b0;
            r_tx_din    <= 8'h00;
            r_req_ready <= '0;
            r_busy      <= 1'b0;
            r_pkt_abort <= 1'b0;
        end else begin
            r_tx_start  <= 1'b0;
            r_req_ready <= '0;
            r_pkt_abort <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_winner;
                        r_cnt   <= 8'd0;
                        r_busy  <= 1'b1;
`ifdef UART_TX_ARB_SRC_ID_EN
                        r_state    <= ST_HDR;
                        r_tx_start <= 1'b1;
                        r_tx_din   <= src_tag(4'(w_winner));
`else
                        r_state     <= ST_SEND;
                        r_tx_start  <= 1'b1;
                        r_tx_din    <= w_win_data;
                        r_req_ready <= w_win_onehot;
                        r_last      <= req_last[w_winner];
`endif
                    end
                end
                ST_SEND: begin
                    r_cnt   <= r_cnt + 8'd1;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (tx_done_tick) begin
                        if (r_last) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else if (r_cnt == 8'(PKT_MAX)) begin
                            r_state     <= ST_IDLE;
                            r_busy      <= 1'b0;
                            r_pkt_abort <= 1'b1;
                        end else begin
                            r_state <= ST_NEXT;
                        end
                    end
                end
                ST_NEXT: begin
                    // Grant stays locked to the owner until its packet ends.
                    if (req_valid[r_grant]) begin
                        r_state     <= ST_SEND;
                        r_tx_start  <= 1'b1;
                        r_tx_din    <= w_own_data;
                        r_req_ready <= w_own_onehot;
                        r_last      <= req_last[r_grant];
                    end
                end
`ifdef UART_TX_ARB_SRC_ID_EN
                ST_HDR: begin
                    // Owner may have dropped valid during the header; park in NEXT if so.
                    if (tx_done_tick) begin
                        if (req_valid[r_grant]) begin
                            r_state     <= ST_SEND;
                            r_tx_start  <= 1'b1;
                            r_tx_din    <= w_own_data;
                            r_req_ready <= w_own_onehot;
                            r_last      <= req_last[r_grant];
                        end else begin
                            r_state <= ST_NEXT;
                        end
                    end
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign tx_start  = r_tx_start;
    assign tx_din    = r_tx_din;
    assign busy      = r_busy;
    assign grant_id  = r_grant;
    assign pkt_abort = r_pkt_abort;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester queues, a fixed-latency transmitter
// model and hand-computed expected tx sequences.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_din;
    logic        tx_done_tick;
    logic        busy;
    logic [1:0]  grant_id;
    logic        pkt_abort;

    uart_tx_arbiter #(
        .NUM_REQ (4),
        .IDW     (2),
        .PKT_MAX (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_last     (req_last),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .tx_start     (tx_start),
        .tx_din       (tx_din),
        .tx_done_tick (tx_done_tick),
        .busy         (busy),
        .grant_id     (grant_id),
        .pkt_abort    (pkt_abort)
    );

    always #5 clk = ~clk;

    logic [8:0] src_mem [4][32];
    int         src_len [4];
    int         src_pos [4];
    bit         hold    [4];

    logic [7:0] log_din [64];
    logic [1:0] log_gid [64];
    int         log_cyc [64];
    int         log_n = 0;
    int         cyc = 0;
    int         rdy_n = 0;
    int         abort_n = 0;
    int         abort_cyc = 0;
    int         done_cnt = 0;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    endtask

    // Transmitter model and output monitor: done_tick 10 cycles after each tx_start.
    initial begin
        tx_done_tick = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            tx_done_tick = 1'b0;
            if (reset) begin
                done_cnt = 0;
            end else begin
                if (done_cnt > 0) begin
                    done_cnt--;
                    if (done_cnt == 0) tx_done_tick = 1'b1;
                end
                if (tx_start) begin
                    if (log_n < 64) begin
                        log_din[log_n] = tx_din;
                        log_gid[log_n] = grant_id;
                        log_cyc[log_n] = cyc;
                    end
                    log_n++;
                    done_cnt = 10;
                end
                rdy_n += $countones(req_ready);
                if (pkt_abort) begin
                    abort_n++;
                    abort_cyc = cyc;
                end
            end
        end
    end

    // Requester models: advance on the edge that closes a req_ready cycle.
    initial begin
        logic [3:0] rs;
        for (int i = 0; i < 4; i++) begin
            src_pos[i] = 0;
        end
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        forever begin
            @(negedge clk);
            rs = req_ready;
            @(posedge clk);
            #2;
            for (int i = 0; i < 4; i++) begin
                if (rs[i] && src_pos[i] < src_len[i]) src_pos[i]++;
                if (src_pos[i] < src_len[i]) begin
                    req_valid[i]       = !hold[i];
                    req_data[8*i +: 8] = src_mem[i][src_pos[i]][7:0];
                    req_last[i]        = src_mem[i][src_pos[i]][8];
                end else begin
                    req_valid[i]       = 1'b0;
                    req_data[8*i +: 8] = 8'h00;
                    req_last[i]        = 1'b0;
                end
            end
        end
    end

    task automatic push(input int i, input logic [7:0] d, input logic l);
        src_mem[i][src_len[i]] = {l, d};
        src_len[i]++;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_log(input int target, input int budget);
        int t = 0;
        while (log_n < target && t < budget) begin
            tick(1);
            t++;
        end
        chk("wait_tx_start", 32'(log_n >= target), 1);
    endtask

    task automatic wait_idle(input int budget);
        int t = 0;
        while (busy && t < budget) begin
            tick(1);
            t++;
        end
        chk("wait_idle", 32'(busy), 0);
    endtask

    initial begin
        int b;
        int r0;
        int a0;
        int k0;
        for (int i = 0; i < 4; i++) begin
            src_len[i] = 0;
            hold[i]    = 1'b0;
        end
        reset = 1'b1;
        tick(3);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_grant", 32'(grant_id), 3);
        chk("rst_tx_start", 32'(tx_start), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_pkt_abort", 32'(pkt_abort), 0);
        chk("rst_tx_din", 32'(tx_din), 0);
        reset = 1'b0;
        tick(1);

`ifdef UART_TX_ARB_SRC_ID_EN
        b  = log_n;
        r0 = rdy_n;
        push(1, 8'h55, 1'b1);
        wait_log(b + 2, 100);
        wait_idle(50);
        chk("hdr_din", 32'(log_din[b]), 32'hA1);
        chk("hdr_gid", 32'(log_gid[b]), 1);
        chk("hdr_data", 32'(log_din[b+1]), 32'h55);
        chk("hdr_data_gid", 32'(log_gid[b+1]), 1);
        chk("hdr_ready_count", 32'(rdy_n - r0), 1);
        chk("hdr_tx_count", 32'(log_n - b), 2);
`else
        // Single 3-byte packet from requester 2
        b  = log_n;
        r0 = rdy_n;
        k0 = cyc;
        push(2, 8'h11, 1'b0);
        push(2, 8'h22, 1'b0);
        push(2, 8'h33, 1'b1);
        wait_log(b + 3, 200);
        wait_idle(50);
        chk("pkt_latency", 32'(log_cyc[b] - k0), 2);
        chk("pkt_spacing", 32'(log_cyc[b+1] - log_cyc[b]), 12);
        for (int k = 0; k < 3; k++) begin
            chk("pkt_din", 32'(log_din[b+k]), 32'h11 * (k + 1));
            chk("pkt_gid", 32'(log_gid[b+k]), 2);
        end
        chk("pkt_ready_count", 32'(rdy_n - r0), 3);
        chk("pkt_idle_grant", 32'(grant_id), 2);

        // Round robin after reset: order 0,1,2,3,0,1,2,3
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        b = log_n;
        for (int i = 0; i < 4; i++) begin
            push(i, 8'(8'h40 + i), 1'b1);
            push(i, 8'(8'h50 + i), 1'b1);
        end
        wait_log(b + 8, 400);
        for (int k = 0; k < 8; k++) begin
            chk("rr_gid", 32'(log_gid[b+k]), k % 4);
            chk("rr_din", 32'(log_din[b+k]), ((k < 4) ? 32'h40 : 32'h50) + (k % 4));
        end
        wait_idle(50);

        // Packet lock: owner 0 stalls mid-packet while requester 1 waits
        b = log_n;
        push(0, 8'h61, 1'b0);
        push(0, 8'h62, 1'b1);
        push(1, 8'h71, 1'b1);
        wait_log(b + 1, 50);
        hold[0] = 1'b1;
        tick(30);
        chk("lock_no_start", 32'(log_n - b), 1);
        chk("lock_grant", 32'(grant_id), 0);
        chk("lock_busy", 32'(busy), 1);
        hold[0] = 1'b0;
        wait_log(b + 3, 100);
        chk("lock_din0", 32'(log_din[b]), 32'h61);
        chk("lock_din1", 32'(log_din[b+1]), 32'h62);
        chk("lock_gid1", 32'(log_gid[b+1]), 0);
        chk("lock_din2", 32'(log_din[b+2]), 32'h71);
        chk("lock_gid2", 32'(log_gid[b+2]), 1);
        wait_idle(50);

        // Forced release after 4 bytes, then requester 3 wins again
        b  = log_n;
        a0 = abort_n;
        for (int k = 0; k < 6; k++) push(3, 8'(8'h81 + k), 1'b0);
        push(3, 8'h87, 1'b1);
        wait_log(b + 7, 300);
        wait_idle(50);
        for (int k = 0; k < 7; k++) begin
            chk("max_din", 32'(log_din[b+k]), 32'h81 + k);
            chk("max_gid", 32'(log_gid[b+k]), 3);
        end
        chk("max_abort_count", 32'(abort_n - a0), 1);
        chk("max_abort_time", 32'(abort_cyc - log_cyc[b+3]), 11);
        chk("max_rearb_time", 32'(log_cyc[b+4] - abort_cyc), 1);

        // Reset during WAIT, then requester 0 favoured over 2
        b = log_n;
        push(1, 8'h91, 1'b0);
        push(1, 8'h92, 1'b1);
        wait_log(b + 1, 50);
        tick(2);
        reset = 1'b1;
        tick(1);
        chk("wrst_busy", 32'(busy), 0);
        chk("wrst_grant", 32'(grant_id), 3);
        chk("wrst_ready", 32'(req_ready), 0);
        chk("wrst_tx_start", 32'(tx_start), 0);
        reset = 1'b0;
        push(0, 8'hA5, 1'b1);
        push(2, 8'hB5, 1'b1);
        wait_log(b + 4, 200);
        chk("wrst_gid0", 32'(log_gid[b+1]), 0);
        chk("wrst_din0", 32'(log_din[b+1]), 32'hA5);
        chk("wrst_gid1", 32'(log_gid[b+2]), 1);
        chk("wrst_din1", 32'(log_din[b+2]), 32'h92);
        chk("wrst_gid2", 32'(log_gid[b+3]), 2);
        chk("wrst_din2", 32'(log_din[b+3]), 32'hB5);
        wait_idle(50);
        chk("wrst_no_abort", 32'(abort_n - a0), 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between NUM_REQ byte-stream requesters, using round-robin arbitration.
- A grant is held for a whole packet (through the byte flagged last), so packets from different sources never interleave on the line.
- Launches each byte with a one-cycle tx_start, then waits for the transmitter's tx_done_tick before issuing the next.
- Sits between the UART transmitter and the system's message sources (status, debug, response paths).

Parameters:
- NUM_REQ, 4, number of requesters; range 2..16.
- IDW, 2, grant index width; must equal clog2(NUM_REQ).
- PKT_MAX, 64, maximum bytes per grant before forced release; range 1..255.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester byte available.
- req_last  input  NUM_REQ  per-requester: presented byte ends the packet.
- req_data  input  NUM_REQ*8  requester i's byte at [8i+7:8i].
- req_ready  output  NUM_REQ  one-hot pulse: byte of requester i accepted this cycle.
- tx_start  output  1  one-cycle launch pulse to the transmitter.
- tx_din  output  8  byte to transmit; valid while tx_start=1.
- tx_done_tick  input  1  transmitter frame-complete pulse.
- busy  output  1  high whenever state is not IDLE.
- grant_id  output  IDW  index of the current owner; holds its last value in IDLE.
- pkt_abort  output  1  one-cycle pulse on forced release at PKT_MAX.

Behaviour:
- Interface fixed: one clock (clk); reset synchronous, active-high, named reset.
- Reset values:
  - state IDLE; tx_start=0, req_ready=0, busy=0, pkt_abort=0, tx_din=0.
  - grant_id=NUM_REQ-1, so requester 0 has top priority on the first arbitration.
  - byte counter=0.
- States: IDLE, SEND, WAIT, NEXT (plus HDR when the optional feature is enabled).
- IDLE:
  - If any req_valid is high, pick the first valid requester scanning from grant_id+1, wrapping modulo NUM_REQ.
  - Register the winner in grant_id, clear the byte counter, go to SEND.
- SEND (exactly 1 cycle):
  - tx_start=1, tx_din=req_data[grant_id], req_ready[grant_id]=1, counter incremented.
  - Latch req_last[grant_id]; go to WAIT.
- WAIT:
  - Hold until tx_done_tick. tx_start stays low; tx_done_tick outside WAIT is ignored.
  - On tx_done_tick: if the latched last=1, go to IDLE. Else if counter==PKT_MAX, pulse pkt_abort and go to IDLE. Else go to NEXT.
- NEXT:
  - Wait for req_valid[grant_id], then go to SEND.
  - Other requesters are not considered; the grant stays locked, with no timeout.
- Latency and throughput:
  - req_valid rising while IDLE -> tx_start on the second clock edge after it (IDLE edge registers the grant, SEND cycle follows).
  - tx_done_tick -> next tx_start 2 cycles later if the owner's valid is already high.
- req_ready, tx_start and tx_din are decoded from registered state/grant only, never from req_valid combinationally.
- A requester may drop req_valid outside SEND without penalty. A byte counts as consumed only on a req_ready pulse.
- Simultaneous events:
  - All requesters valid in IDLE -> grant_id+1 (mod NUM_REQ) wins.
  - The sole valid requester equal to the previous owner still wins.
- Reset in any state -> IDLE on the next edge. A partially sent packet is abandoned; no pkt_abort is raised.

Optional Feature:
- Macro: UART_TX_ARB_SRC_ID_EN.
- Defined:
  - IDLE goes to HDR instead of SEND.
  - HDR issues tx_start with tx_din = 8'hA0 | grant_id, with no req_ready pulse, then waits for tx_done_tick and goes to SEND.
  - The header does not count toward PKT_MAX.
- Undefined: no HDR state; the byte stream carries no source tag.

Decomposition:
- Package uart_arb_pkg holds:
  - state encoding localparams: IDLE=0, SEND=1, WAIT=2, NEXT=3, HDR=4; state width 3.
  - SRC_ID_TAG=8'hA0.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req vector, last index. Outputs: any, winner index.
  - Parameterised by NUM_REQ; instantiated once.

Test Plan:
- Single packet: requester 2 sends 3 bytes 0x11, 0x22, 0x33 (last on 0x33), bench returns tx_done_tick 10 cycles after each tx_start -> three tx_start pulses with those bytes, grant_id=2 throughout, then IDLE with busy=0.
- Round-robin fairness: all four requesters send 1-byte packets continuously after reset -> grant order 0, 1, 2, 3, 0.
- Packet lock: requester 0 mid-packet drops valid for 20 cycles while requester 1 is valid -> no tx_start and grant_id stays 0; resumes when valid 0 returns.
- PKT_MAX=4, requester 3 streams 6 bytes with no last -> 4 bytes sent, pkt_abort pulses after the 4th tx_done_tick, then re-arbitration.
- Reset asserted during WAIT -> IDLE next cycle, req_ready=0, grant_id=NUM_REQ-1; the next arbitration favours requester 0.
- UART_TX_ARB_SRC_ID_EN defined, requester 1 sends 0x55 (last) -> tx_din sequence 0xA1 then 0x55; exactly one req_ready pulse.
